// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Registered, valid/ready-handshaked RISC-V immediate generator.
//               Decodes the immediate format of an instruction, produces the
//               sign/zero-extended immediate and the PC-relative target, and
//               buffers results in an output register plus one skid register.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter bit EN_CSR = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_tgt;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  // Input-side decode: format, extended immediate, target, illegal flag
  always_comb begin
    dec_imm = '0;
    dec_tgt = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_fmt = FMT_I;
        dec_imm = XLEN'($signed(in_instr[31:20]));
      end
      7'b0011011: begin
        // OP-IMM-32 exists only on RV64
        if (XLEN == 64) begin
          dec_fmt = FMT_I;
          dec_imm = XLEN'($signed(in_instr[31:20]));
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
        dec_tgt = in_pc + dec_imm;
      end
      7'b0110111: begin
        dec_fmt = FMT_U;
        dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
        dec_tgt = dec_imm;
      end
      7'b0010111: begin
        dec_fmt = FMT_U;
        dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
        dec_tgt = in_pc + dec_imm;
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
        dec_tgt = in_pc + dec_imm;
      end
      7'b1110011: begin
        // funct3=000 (ECALL/EBREAK/xRET) carries no immediate
        if (EN_CSR && funct3[2]) begin
          dec_fmt = FMT_Z;
          dec_imm = XLEN'(in_instr[19:15]);
        end else if (EN_CSR && (funct3 != 3'b000)) begin
          dec_fmt = FMT_Z;
          dec_imm = XLEN'(in_instr[31:20]);
        end
      end
      7'b0110011, 7'b0001111: begin
        dec_fmt = FMT_NONE;
      end
      7'b0111011: begin
        dec_ill = (XLEN != 64);
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
  end

  logic            or_valid_q, or_valid_d;
  logic [XLEN-1:0] or_imm_q,   or_imm_d;
  logic [XLEN-1:0] or_tgt_q,   or_tgt_d;
  logic [2:0]      or_fmt_q,   or_fmt_d;
  logic            or_ill_q,   or_ill_d;
  logic            sk_valid_q, sk_valid_d;
  logic [XLEN-1:0] sk_imm_q,   sk_imm_d;
  logic [XLEN-1:0] sk_tgt_q,   sk_tgt_d;
  logic [2:0]      sk_fmt_q,   sk_fmt_d;
  logic            sk_ill_q,   sk_ill_d;
  logic            in_ready_q, in_ready_d;

  logic accept;
  logic xfer;

  assign accept = in_valid && in_ready_q;
  assign xfer   = or_valid_q && out_ready;

  // Skid-buffer next state; flush dominates, SK always refills OR first
  always_comb begin
    or_valid_d = or_valid_q;
    or_imm_d   = or_imm_q;
    or_tgt_d   = or_tgt_q;
    or_fmt_d   = or_fmt_q;
    or_ill_d   = or_ill_q;
    sk_valid_d = sk_valid_q;
    sk_imm_d   = sk_imm_q;
    sk_tgt_d   = sk_tgt_q;
    sk_fmt_d   = sk_fmt_q;
    sk_ill_d   = sk_ill_q;
    if (flush) begin
      or_valid_d = 1'b0;
      sk_valid_d = 1'b0;
    end else if (!or_valid_q || xfer) begin
      if (sk_valid_q) begin
        // in_ready is low whenever SK is full, so no accept can collide here
        or_valid_d = 1'b1;
        or_imm_d   = sk_imm_q;
        or_tgt_d   = sk_tgt_q;
        or_fmt_d   = sk_fmt_q;
        or_ill_d   = sk_ill_q;
        sk_valid_d = 1'b0;
      end else if (accept) begin
        or_valid_d = 1'b1;
        or_imm_d   = dec_imm;
        or_tgt_d   = dec_tgt;
        or_fmt_d   = dec_fmt;
        or_ill_d   = dec_ill;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (accept) begin
      sk_valid_d = 1'b1;
      sk_imm_d   = dec_imm;
      sk_tgt_d   = dec_tgt;
      sk_fmt_d   = dec_fmt;
      sk_ill_d   = dec_ill;
    end
    in_ready_d = !sk_valid_d;
  end

  // State and data registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid_q <= 1'b0;
      or_imm_q   <= '0;
      or_tgt_q   <= '0;
      or_fmt_q   <= FMT_NONE;
      or_ill_q   <= 1'b0;
      sk_valid_q <= 1'b0;
      sk_imm_q   <= '0;
      sk_tgt_q   <= '0;
      sk_fmt_q   <= FMT_NONE;
      sk_ill_q   <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      or_valid_q <= or_valid_d;
      or_imm_q   <= or_imm_d;
      or_tgt_q   <= or_tgt_d;
      or_fmt_q   <= or_fmt_d;
      or_ill_q   <= or_ill_d;
      sk_valid_q <= sk_valid_d;
      sk_imm_q   <= sk_imm_d;
      sk_tgt_q   <= sk_tgt_d;
      sk_fmt_q   <= sk_fmt_d;
      sk_ill_q   <= sk_ill_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = or_valid_q;
  assign out_imm     = or_imm_q;
  assign out_target  = or_tgt_q;
  assign out_fmt     = or_fmt_q;
  assign out_illegal = or_ill_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Scoreboard bench for imm_gen_pipe (XLEN=32 and XLEN=64 copies).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_imm;
  logic [31:0] out_target;
  logic [2:0]  out_fmt;
  logic        out_illegal;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [31:0] in_instr64 = '0;
  logic [63:0] in_pc64 = '0;
  logic        out_valid64;
  logic        out_ready64 = 1'b1;
  logic [63:0] out_imm64;
  logic [63:0] out_target64;
  logic [2:0]  out_fmt64;
  logic        out_illegal64;

  exp_t sb32[$];
  exp_t sb64[$];
  vec_t v32[$];
  vec_t v64[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   c0 = 0;
  bit   done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imm_gen_pipe #(.XLEN(32), .EN_CSR(1'b1)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_target(out_target), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .EN_CSR(1'b1)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64),
    .out_target(out_target64), .out_fmt(out_fmt64), .out_illegal(out_illegal64)
  );

  function automatic vec_t mk(input logic [31:0] ins, input logic [63:0] pc,
                              input logic [63:0] imm, input logic [63:0] tgt,
                              input logic [2:0] fmt, input logic ill);
    vec_t v;
    v.ins = ins;
    v.pc  = pc;
    v.e   = '{imm: imm, tgt: tgt, fmt: fmt, ill: ill};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic send32(input vec_t v);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_instr = v.ins;
    in_pc    = v.pc[31:0];
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        acc = 1'b1;
        sb32.push_back(v.e);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_vec++;
      n_fail++;
      $display("FAIL send32_timeout: got no accept expected accept for %h", v.ins);
    end
  endtask

  task automatic send64(input vec_t v);
    bit acc;
    acc = 1'b0;
    in_valid64 = 1'b1;
    in_instr64 = v.ins;
    in_pc64    = v.pc;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (in_ready64 && !flush) begin
        acc = 1'b1;
        sb64.push_back(v.e);
      end
      @(posedge clk);
      #1;
    end
    in_valid64 = 1'b0;
    if (!acc) begin
      n_vec++;
      n_fail++;
      $display("FAIL send64_timeout: got no accept expected accept for %h", v.ins);
    end
  endtask

  // Compares the presented output with the queue head; pops on transfer
  task automatic mon32();
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        n_vec++;
        if (sb32.size() == 0) begin
          n_fail++;
          $display("FAIL out32_unexpected: got imm=%h with no expected entry", out_imm);
        end else begin
          e = sb32[0];
          if ({32'b0, out_imm} !== e.imm || {32'b0, out_target} !== e.tgt ||
              out_fmt !== e.fmt || out_illegal !== e.ill) begin
            n_fail++;
            $display("FAIL out32: got imm=%h tgt=%h fmt=%0d ill=%0b expected imm=%h tgt=%h fmt=%0d ill=%0b",
                     out_imm, out_target, out_fmt, out_illegal, e.imm[31:0], e.tgt[31:0], e.fmt, e.ill);
          end
          if (out_ready) void'(sb32.pop_front());
        end
      end
    end
  endtask

  task automatic mon64();
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (rst_n && out_valid64) begin
        n_vec++;
        if (sb64.size() == 0) begin
          n_fail++;
          $display("FAIL out64_unexpected: got imm=%h with no expected entry", out_imm64);
        end else begin
          e = sb64[0];
          if (out_imm64 !== e.imm || out_target64 !== e.tgt ||
              out_fmt64 !== e.fmt || out_illegal64 !== e.ill) begin
            n_fail++;
            $display("FAIL out64: got imm=%h tgt=%h fmt=%0d ill=%0b expected imm=%h tgt=%h fmt=%0d ill=%0b",
                     out_imm64, out_target64, out_fmt64, out_illegal64, e.imm, e.tgt, e.fmt, e.ill);
          end
          if (out_ready64) void'(sb64.pop_front());
        end
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_out_imm"},   64'(out_imm),   64'd0);
    check({tag, "_out_target"}, 64'(out_target), 64'd0);
    check({tag, "_out_fmt"},   64'(out_fmt),   64'd0);
    check({tag, "_out_ill"},   64'(out_illegal), 64'd0);
  endtask

  task automatic stimulus();
    // Directed decode vectors, streamed back to back
    v32.push_back(mk(32'hFFF00093, 64'h0,    64'hFFFFFFFF, 64'h0,        3'd1, 1'b0));
    v32.push_back(mk(32'hFE000EE3, 64'h100,  64'hFFFFFFFC, 64'hFC,       3'd3, 1'b0));
    v32.push_back(mk(32'h0010006F, 64'h1000, 64'h800,      64'h1800,     3'd5, 1'b0));
    v32.push_back(mk(32'h123452B7, 64'h0,    64'h12345000, 64'h12345000, 3'd4, 1'b0));
    v32.push_back(mk(32'h3002D073, 64'h0,    64'h5,        64'h0,        3'd6, 1'b0));
    v32.push_back(mk(32'h0000007F, 64'h0,    64'h0,        64'h0,        3'd0, 1'b1));
    v32.push_back(mk(32'h0000001B, 64'h0,    64'h0,        64'h0,        3'd0, 1'b1));
    v32.push_back(mk(32'h0000003B, 64'h0,    64'h0,        64'h0,        3'd0, 1'b1));
    v32.push_back(mk(32'hFE112E23, 64'h40,   64'hFFFFFFFC, 64'h0,        3'd2, 1'b0));
    v32.push_back(mk(32'h00001517, 64'h2000, 64'h1000,     64'h3000,     3'd4, 1'b0));
    v32.push_back(mk(32'h00C08067, 64'h500,  64'hC,        64'h0,        3'd1, 1'b0));
    v32.push_back(mk(32'h30002573, 64'h0,    64'h300,      64'h0,        3'd6, 1'b0));
    v32.push_back(mk(32'hFFF03073, 64'h0,    64'hFFF,      64'h0,        3'd6, 1'b0));
    v32.push_back(mk(32'h002081B3, 64'h0,    64'h0,        64'h0,        3'd0, 1'b0));
    v32.push_back(mk(32'h00000073, 64'h0,    64'h0,        64'h0,        3'd0, 1'b0));
    v32.push_back(mk(32'h800000B7, 64'h0,    64'h80000000, 64'h80000000, 3'd4, 1'b0));
    v32.push_back(mk(32'hFE000EE3, 64'h0,    64'hFFFFFFFC, 64'hFFFFFFFC, 3'd3, 1'b0));

    c0 = cyc;
    foreach (v32[i]) send32(v32[i]);
    check("throughput_cycles", 64'(cyc - c0), 64'(v32.size()));
    repeat (3) @(posedge clk);
    #1;
    check("drain32", 64'(sb32.size()), 64'd0);

    v64.push_back(mk(32'hFE000EE3, 64'h0, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0));
    v64.push_back(mk(32'hFFF0009B, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 3'd1, 1'b0));
    v64.push_back(mk(32'h0000003B, 64'h0, 64'h0, 64'h0, 3'd0, 1'b0));
    v64.push_back(mk(32'h800000B7, 64'h0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0));
    v64.push_back(mk(32'h0010006F, 64'hFFFFFFFFFFFFF800, 64'h800, 64'h0, 3'd5, 1'b0));
    foreach (v64[i]) send64(v64[i]);
    repeat (3) @(posedge clk);
    #1;
    check("drain64", 64'(sb64.size()), 64'd0);

    // Stall: A to OR, B to SK, C held off until the consumer drains
    out_ready = 1'b0;
    send32(mk(32'h00100093, 64'h0, 64'h1, 64'h0, 3'd1, 1'b0));
    send32(mk(32'h00200093, 64'h0, 64'h2, 64'h0, 3'd1, 1'b0));
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    fork
      send32(mk(32'h00300093, 64'h0, 64'h3, 64'h0, 3'd1, 1'b0));
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("nogap_out_valid", 64'(out_valid), 64'd1);
        end
      end
    join
    @(posedge clk);
    #1;
    check("post_stall_in_ready", 64'(in_ready), 64'd1);
    check("post_stall_drain", 64'(sb32.size()), 64'd0);

    // Flush with OR and SK full and a new input offered
    out_ready = 1'b0;
    send32(mk(32'h00400093, 64'h0, 64'h4, 64'h0, 3'd1, 1'b0));
    send32(mk(32'h00500093, 64'h0, 64'h5, 64'h0, 3'd1, 1'b0));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00600093;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb32.delete();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("flush_stays_empty", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send32(mk(32'h00700093, 64'h0, 64'h7, 64'h0, 3'd1, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    check("flush_recover_drain", 64'(sb32.size()), 64'd0);

    // Asynchronous reset in the middle of a cycle with OR and SK full
    out_ready = 1'b0;
    send32(mk(32'h123452B7, 64'h0, 64'h12345000, 64'h12345000, 3'd4, 1'b0));
    send32(mk(32'hFFF00093, 64'h0, 64'hFFFFFFFF, 64'h0, 3'd1, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    sb32.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    send32(mk(32'h0010006F, 64'h1000, 64'h800, 64'h1800, 3'd5, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_drain", 64'(sb32.size()), 64'd0);
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    fork
      mon32();
      mon64();
      begin
        stimulus();
        done = 1'b1;
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
